// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Multi-cycle data memory that answers the CPU's MEM-stage load/store requests
// over a request/response handshake. It stands in for the zero-latency data
// memory so the pipeline can be run against slow memory. While a request is
// outstanding, stall_o freezes the pipeline.
//
// Store data is taken from the low bytes of wdata_i and moved onto the byte
// lanes selected by addr[1:0]. For example, a byte store to 0x11 writes
// wdata_i[7:0] into bits 15:8 of the word. be_i names the memory lanes that
// are written.
//
// Parameters:
//   DEPTH_WORDS  number of 32-bit words (index 0..DEPTH_WORDS-1)
//   LATENCY      cycles from accept to response, must be >= 1
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   req_i        request valid, sampled when ready_o=1
//   we_i         1=store, 0=load
//   addr_i       byte address
//   wdata_i      store data (low-aligned)
//   be_i         store byte enables, memory lanes
//   ready_o      a request can be accepted this cycle
//   rsp_valid_o  one-cycle response strobe
//   rdata_o      load data, zero outside a load response
//   err_o        range/alignment error, valid with rsp_valid_o
//   stall_o      pipeline freeze request
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = $clog2(LATENCY + 1);

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;

    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_be;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              enter_resp;
    logic              c_we;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic [3:0]        c_be;
    logic [IDX_W-1:0]  c_idx;
    logic [31:0]       c_wshift;
    logic              c_oor;
    logic              c_err;
    logic [31:0]       rdata_q;
    logic              err_q;

    assign ready_o     = (state != WAIT);
    assign accept      = req_i & ready_o;
    assign stall_o     = accept | (state == WAIT);
    assign rsp_valid_o = (state == RESP);
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;

    // With a single-cycle latency the commit happens on the accept edge.
    // The request being committed is therefore the live input rather than
    // the latched copy. Longer latencies always commit from the latched copy.
    if (LATENCY == 1) begin : g_commit_live
        assign c_we    = we_i;
        assign c_addr  = addr_i;
        assign c_wdata = wdata_i;
        assign c_be    = be_i;
    end else begin : g_commit_latched
        assign c_we    = lat_we;
        assign c_addr  = lat_addr;
        assign c_wdata = lat_wdata;
        assign c_be    = lat_be;
    end

    assign c_idx    = c_addr[IDX_W+1:2];
    assign c_wshift = c_wdata << {c_addr[1:0], 3'b000};
    assign c_oor    = ((c_addr >> (IDX_W + 2)) != 32'd0) ||
                      (32'(c_idx) >= 32'(DEPTH_WORDS));

    assign enter_resp = (LATENCY == 1) ? accept
                                       : ((state == WAIT) && (cnt == CNT_W'(1)));

    // Error classification of the request being committed.
    // Loads must be word aligned.
    // Stores must use a byte, halfword or word lane pattern that starts at
    // addr[1:0]. An empty byte-enable pattern is treated as illegal.
    always_comb begin
        c_err = c_oor;
        if (!c_we) begin
            if (c_addr[1:0] != 2'b00)
                c_err = 1'b1;
        end else begin
            case (c_addr[1:0])
                2'd0:    if (!(c_be inside {4'b1111, 4'b0011, 4'b0001})) c_err = 1'b1;
                2'd1:    if (c_be != 4'b0010) c_err = 1'b1;
                2'd2:    if (!(c_be inside {4'b1100, 4'b0100})) c_err = 1'b1;
                default: if (c_be != 4'b1000) c_err = 1'b1;
            endcase
        end
    end

    // Next-state logic.
    // RESP behaves exactly like IDLE for a new request, which is what makes
    // back-to-back operation possible. Requests seen during WAIT are ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, RESP: begin
                if (accept)
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                else
                    state_next = IDLE;
            end
            WAIT: begin
                if (cnt == CNT_W'(1))
                    state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers.
    // The counter is reloaded on every accept and only counts down in WAIT.
    // The response data and error registers are loaded on the edge that
    // enters RESP and are forced back to zero on every other edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt       <= CNT_W'(LATENCY - 1);
                lat_we    <= we_i;
                lat_addr  <= addr_i;
                lat_wdata <= wdata_i;
                lat_be    <= be_i;
            end else if (state == WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (enter_resp) begin
                err_q   <= c_err;
                rdata_q <= (!c_we && !c_err) ? mem[c_idx] : 32'd0;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Word array, intentionally not reset.
    // A store commits only on the edge that enters RESP, so a reset during
    // the wait period discards the store.
    always_ff @(posedge clk_i) begin
        if (enter_resp && c_we && !c_err && !rst_i) begin
            for (int k = 0; k < 4; k++) begin
                if (c_be[k])
                    mem[c_idx][8*k +: 8] <= c_wshift[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. It runs two instances:
//   u_dut_a  LATENCY=4, used for directed and random transactions
//   u_dut_b  LATENCY=1, driven with continuous back-to-back traffic
//
// Expected values come from a transaction-level model. Each access is
// checked for legality from the byte-enable population count and the
// address offset. Stores are applied byte by byte to a reference array.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;

    logic        req_a, we_a, ready_a, rsp_a, err_a, stall_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;

    logic        req_b, we_b, ready_b, rsp_b, err_b, stall_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] ref_mem [2][DEPTH];

    // {offset, byte enables} pairs that form legal stores
    logic [5:0] legal_tab [7] = '{6'h0F, 6'h03, 6'h2C, 6'h01, 6'h12, 6'h24, 6'h38};

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;
    rsp_t exp_q [$];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) u_dut_a (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_a), .we_i(we_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .be_i(be_a),
        .ready_o(ready_a), .rsp_valid_o(rsp_a), .rdata_o(rdata_a),
        .err_o(err_a), .stall_o(stall_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut_b (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_b), .we_i(we_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .be_i(be_b),
        .ready_o(ready_b), .rsp_valid_o(rsp_b), .rdata_o(rdata_b),
        .err_o(err_b), .stall_o(stall_b)
    );

    // 100 MHz clock
    always #5 clk_i = ~clk_i;

    // Hard stop in case a wait is never satisfied
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want)
            n_pass++;
        else
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    endtask

    // Transaction-level reference. A store is legal when its enabled bytes
    // form a contiguous run of 1, 2 or 4 bytes that starts at the address
    // offset and is size-aligned. Store data arrives low-aligned.
    task automatic modelAccess(input int dut, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               output logic [31:0] exp_data, output logic exp_err);
        int   off;
        int   nbytes;
        int   word;
        logic legal;
        off    = int'(addr[1:0]);
        nbytes = $countones(be);
        if (addr >= 32'(4 * DEPTH))
            legal = 1'b0;
        else if (!we)
            legal = (off == 0);
        else
            legal = (nbytes == 1 || nbytes == 2 || nbytes == 4) && (off % nbytes == 0) &&
                    (be == 4'(((1 << nbytes) - 1) << off));
        exp_err  = !legal;
        exp_data = 32'd0;
        if (legal) begin
            word = int'(addr >> 2);
            if (!we)
                exp_data = ref_mem[dut][word];
            else
                for (int k = 0; k < 4; k++)
                    if (be[k]) ref_mem[dut][word][8*k +: 8] = wdata[8*(k-off) +: 8];
        end
    endtask

    // Random operation, mostly legal, with occasional illegal patterns and
    // out-of-range addresses
    task automatic genOp(input int max_word, input bit allow_oor, output logic we,
                         output logic [31:0] addr, output logic [31:0] wdata, output logic [3:0] be);
        logic [5:0] pair;
        int         word;
        we    = 1'($urandom_range(0, 1));
        word  = int'($urandom_range(0, max_word));
        wdata = $urandom;
        if ($urandom_range(0, 3) == 0)
            pair = 6'($urandom);
        else
            pair = legal_tab[$urandom_range(0, 6)];
        be   = pair[3:0];
        addr = (32'(word) << 2) | 32'(pair[5:4]);
        if (!we && $urandom_range(0, 1) == 0)
            addr[1:0] = 2'b00;
        if (allow_oor && $urandom_range(0, 15) == 0)
            addr = addr | ($urandom & 32'hFFFF_FC00) | 32'h0000_0400;
    endtask

    // Drive one request on DUT A in the current cycle and check the accept
    // cycle. Returns one cycle later with the request dropped and the inputs
    // scrambled, which proves the DUT latched them.
    task automatic issueRequest(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] be, input string tag,
                                output logic [31:0] exp_d, output logic exp_e);
        modelAccess(0, we, addr, wdata, be, exp_d, exp_e);
        req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wdata; be_a = be;
        @(negedge clk_i);
        checkOutput({tag, ".accept"}, 32'({ready_a, stall_a, rsp_a}), 32'b110);
        @(posedge clk_i); #1;
        req_a = 1'b0; we_a = 1'($urandom); addr_a = $urandom; wdata_a = $urandom; be_a = 4'($urandom);
    endtask

    // Wait for the response, up to a bounded number of cycles. Checks the
    // stall/ready levels while waiting, the exact latency, the response
    // payload, and that the outputs clear again afterwards.
    task automatic waitResponse(input string tag, input logic [31:0] exp_d, input logic exp_e);
        int lat;
        lat = 1;
        @(negedge clk_i);
        while (!rsp_a && lat < LAT_A + 8) begin
            checkOutput({tag, ".wait"}, 32'({ready_a, stall_a}), 32'b01);
            @(negedge clk_i);
            lat++;
        end
        checkOutput({tag, ".latency"}, 32'(lat), 32'(LAT_A));
        checkOutput({tag, ".rdata"}, rdata_a, exp_d);
        checkOutput({tag, ".err"}, 32'(err_a), 32'(exp_e));
        checkOutput({tag, ".resp_ctl"}, 32'({ready_a, stall_a}), 32'b10);
        @(posedge clk_i); #1;
        checkOutput({tag, ".after"}, 32'({rsp_a, err_a}) | rdata_a, 32'd0);
    endtask

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input string tag);
        logic [31:0] exp_d;
        logic        exp_e;
        issueRequest(we, addr, wdata, be, tag, exp_d, exp_e);
        waitResponse(tag, exp_d, exp_e);
    endtask

    initial begin
        logic [31:0] exp_d, exp_d2, saved, addr, wdata;
        logic        exp_e, exp_e2, we;
        logic [3:0]  be;
        int          seen;
        rsp_t        r;

        rst_i = 1'b1;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0; be_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0; be_b = '0;
        #2;
        checkOutput("reset_a", 32'({ready_a, rsp_a, err_a, stall_a}) | rdata_a, 32'b1000);
        checkOutput("reset_b", 32'({ready_b, rsp_b, err_b, stall_b}) | rdata_b, 32'b1000);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Fill the array so every word has a known value
        for (int w = 0; w < DEPTH; w++)
            applyStimulus(1'b1, 32'(w * 4), $urandom, 4'hF, "preload");

        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, "load_w0");

        // Full-word store, then a byte merge into lane 1
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_10");
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, "ld_10");
        applyStimulus(1'b1, 32'h11, 32'h000000AA, 4'b0010, "st_11");
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, "ld_10_merged");
        checkOutput("model_merge", ref_mem[0][4], 32'hDEADAAEF);

        // Back-to-back: a load is issued in the store's RESP cycle
        issueRequest(1'b1, 32'h44, 32'hCAFE0123, 4'hF, "b2b_st", exp_d, exp_e);
        repeat (LAT_A - 1) @(posedge clk_i);
        #1;
        modelAccess(0, 1'b0, 32'h44, 32'h0, 4'h0, exp_d2, exp_e2);
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'h44; be_a = 4'h0;
        @(negedge clk_i);
        checkOutput("b2b_st.rsp", 32'({rsp_a, err_a}), 32'b10);
        checkOutput("b2b_st.rdata", rdata_a, exp_d);
        checkOutput("b2b.ctl", 32'({ready_a, stall_a}), 32'b11);
        @(posedge clk_i); #1;
        req_a = 1'b0;
        waitResponse("b2b_ld", exp_d2, exp_e2);

        // Error cases
        applyStimulus(1'b0, 32'h402, 32'h0, 4'h0, "ld_misaligned");
        applyStimulus(1'b0, 32'h400, 32'h0, 4'h0, "ld_oor");
        applyStimulus(1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, "st_oor");
        applyStimulus(1'b1, 32'h22, 32'h0000BEEF, 4'b0110, "st_bad_be");

        // Reset during a pending store must discard it
        saved = ref_mem[0][8];
        issueRequest(1'b1, 32'h20, ~saved, 4'hF, "rst_st", exp_d, exp_e);
        ref_mem[0][8] = saved;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        checkOutput("rst_mid", 32'({ready_a, rsp_a, stall_a, err_a}) | rdata_a, 32'b1000);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (rsp_a) seen++;
        end
        checkOutput("rst_no_rsp", 32'(seen), 32'd0);
        @(posedge clk_i); #1;
        applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, "rst_readback");

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            genOp(DEPTH - 1, 1'b1, we, addr, wdata, be);
            applyStimulus(we, addr, wdata, be, "rand");
        end

        // Full readback; also shows that the out-of-range store touched nothing
        for (int w = 0; w < DEPTH; w++)
            applyStimulus(1'b0, 32'(w * 4), 32'h0, 4'h0, "readback");

        // LATENCY=1 instance with continuous requests
        @(posedge clk_i); #1;
        for (int j = 0; j < 40; j++) begin
            if (j < 8) begin
                we = 1'b1; addr = 32'(j * 4); wdata = $urandom; be = 4'hF;
            end else begin
                genOp(7, 1'b0, we, addr, wdata, be);
            end
            modelAccess(1, we, addr, wdata, be, exp_d, exp_e);
            exp_q.push_back('{data: exp_d, err: exp_e});
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wdata; be_b = be;
            @(negedge clk_i);
            checkOutput("lat1.ctl", 32'({ready_b, stall_b}), 32'b11);
            if (j > 0) begin
                r = exp_q.pop_front();
                checkOutput("lat1.rsp", 32'(rsp_b), 32'd1);
                checkOutput("lat1.rdata", rdata_b, r.data);
                checkOutput("lat1.err", 32'(err_b), 32'(r.err));
            end
            @(posedge clk_i); #1;
        end
        req_b = 1'b0;
        @(negedge clk_i);
        r = exp_q.pop_front();
        checkOutput("lat1.last_rsp", 32'({rsp_b, stall_b}), 32'b10);
        checkOutput("lat1.last_rdata", rdata_b, r.data);
        checkOutput("lat1.last_err", 32'(err_b), 32'(r.err));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        checkOutput("lat1.idle", 32'({rsp_b, stall_b}), 32'b00);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
